branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Resolves conditional branches at execute against the direction and target that fetch predicted.
- Raises flush and redirect on a misprediction.
- Returns the actual outcome to the 2-bit branch predictor as its training inputs: branch-command strobe and taken flag.
- Sits between the fetch-side prediction path and the execute stage. Holds in-flight predictions in order in a small FIFO.

Parameters:
- ADDR_W, 32, width of PCs and targets.
- DEPTH, 4, maximum in-flight predicted branches. Must be a power of 2, at least 2.
- FLUSH_CYCLES, 2, cycles oFlush stays high after a mispredict. Minimum 1.

Ports:
- iClk  input  1  clock, rising edge.
- iRst_n  input  1  reset, active-low, asynchronous.
- iPredValid  input  1  fetch pushes one predicted branch this cycle.
- iPredTaken  input  1  predicted direction.
- iPredPC  input  ADDR_W  PC of the branch.
- iPredTarget  input  ADDR_W  predicted taken target.
- oPredFull  output  1  FIFO full; fetch must stall branch issue.
- oEmpty  output  1  no branches in flight.
- iResValid  input  1  execute resolves the oldest in-flight branch.
- iResTaken  input  1  actual direction.
- iResTarget  input  ADDR_W  actual taken target.
- oUpdCmd  output  1  predictor training strobe; drives the predictor's branch-command input.
- oUpdTaken  output  1  actual outcome; drives the predictor's taken input.
- oMispredict  output  1  one-cycle pulse per mispredicted branch.
- oRedirectValid  output  1  one-cycle pulse: fetch must load oRedirectPC.
- oRedirectPC  output  ADDR_W  corrected fetch PC.
- oFlush  output  1  squash younger pipeline contents.

Behaviour:
- Reset (async, iRst_n=0): FIFO empty, state IDLE, all outputs 0 except oEmpty=1. oRedirectPC=0.
- Reset mid-flush aborts the flush immediately.
- FIFO: in-order, entries {taken, PC, target}. Push when iPredValid and not full. Pop when iResValid and not empty.
- Push while full (without a same-cycle pop) is dropped.
- Resolve while empty is ignored and produces no outputs.
- Same-cycle push and pop are legal, including when full; occupancy is unchanged.
- Mispredict rule, comparing against the head entry:
  - (iResTaken != head.taken), or
  - (iResTaken && head.taken && iResTarget != head.target).
- Redirect PC:
  - iResTarget if iResTaken.
  - Otherwise head.PC + 4, computed modulo 2^ADDR_W, wrapping at the top of the address space.
- Latency: resolve at cycle N gives oUpdCmd, oUpdTaken, oMispredict, oRedirectValid and oRedirectPC registered at N+1.
- oUpdCmd pulses for every accepted resolve, correct or not.
- FSM:
  - IDLE: normal. An accepted mispredicting resolve goes to FLUSH, loads the flush counter with FLUSH_CYCLES, and clears the FIFO. Any same-cycle push is discarded as wrong-path.
  - FLUSH: oFlush=1 from N+1 for exactly FLUSH_CYCLES cycles. iPredValid and iResValid are ignored. Returns to IDLE when the counter reaches 0.
- oRedirectValid pulses once, on the first FLUSH cycle. oRedirectPC holds its value until the next redirect.
- oPredFull and oEmpty are registered flags, consistent with occupancy after each edge.

Optional Feature:
- Macro: BRANCH_RESOLVER_STATS_EN.
- Defined: adds outputs oBranchCount[15:0] and oMispredCount[15:0].
  - Incremented on each accepted resolve and each mispredict respectively.
  - Saturate at 16'hFFFF. Cleared by reset.
- Undefined: ports and counters are absent. Remaining behaviour is identical.

Test Plan:
- Correct not-taken: push {taken=0, PC=0x100}, resolve taken=0 -> N+1: oUpdCmd=1, oUpdTaken=0, oMispredict=0, oFlush=0; oEmpty=1.
- Direction mispredict: push {taken=0, PC=0x200}, resolve taken=1, target=0x340 -> N+1: oMispredict=1, oRedirectValid=1, oRedirectPC=0x340, oUpdTaken=1; oFlush high 2 cycles; FIFO empty.
- Target mispredict, plus wrap: push {taken=1, target=0x400}, resolve taken=1, target=0x480 -> redirect 0x480. Then push {taken=1, PC=0xFFFFFFFC}, resolve taken=0 -> oRedirectPC=0x00000000.
- Full/overflow: push 5 branches with no resolve -> oPredFull=1 after 4th, 5th dropped. Then same-cycle push+correct-resolve keeps occupancy 4. Four more resolves empty the FIFO and produce exactly 4 oUpdCmd pulses.
- Flush masking: mispredict with 3 entries queued and a same-cycle push -> FIFO cleared, pushed entry dropped. iResValid during FLUSH yields no oUpdCmd.
- Async reset in FLUSH: drop iRst_n mid-flush between edges -> oFlush, oRedirectValid, oUpdCmd=0 immediately, oEmpty=1. With STATS_EN, counters read 0. A separate run of 70000 mispredicts -> oMispredCount=16'hFFFF.

Source files
------------

// File: rtl/branch_resolver.sv
// Execute-side branch resolver: in-order prediction FIFO, mispredict flush/redirect, predictor training.
// Optional BRANCH_RESOLVER_STATS_EN adds saturating branch/mispredict counters.
module branch_resolver #(
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iPredValid,
  input  logic              iPredTaken,
  input  logic [ADDR_W-1:0] iPredPC,
  input  logic [ADDR_W-1:0] iPredTarget,
  output logic              oPredFull,
  output logic              oEmpty,
  input  logic              iResValid,
  input  logic              iResTaken,
  input  logic [ADDR_W-1:0] iResTarget,
  output logic              oUpdCmd,
  output logic              oUpdTaken,
  output logic              oMispredict,
  output logic              oRedirectValid,
  output logic [ADDR_W-1:0] oRedirectPC,
  output logic              oFlush
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [15:0]       oBranchCount,
  output logic [15:0]       oMispredCount
`endif
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_FLUSH
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [FCW-1:0]     r_fcnt;
  logic [FCW-1:0]     w_fcnt_nxt;

  logic               r_taken [DEPTH];
  logic [ADDR_W-1:0]  r_pc    [DEPTH];
  logic [ADDR_W-1:0]  r_tgt   [DEPTH];
  logic [AW-1:0]      r_wr;
  logic [AW-1:0]      r_rd;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      w_cnt_nxt;
  logic               r_full;
  logic               r_empty;

  logic               r_upd_cmd;
  logic               r_upd_taken;
  logic               r_mis;
  logic               r_redir_v;
  logic [ADDR_W-1:0]  r_redir_pc;

  logic               w_idle;
  logic               w_pop;
  logic               w_push;
  logic               w_mis;
  logic [ADDR_W-1:0]  w_redir_pc;

  assign w_idle = (r_state == S_IDLE);
  assign w_pop  = w_idle & iResValid & ~r_empty;

  assign w_mis = w_pop &
    ((iResTaken != r_taken[r_rd]) |
     (iResTaken & r_taken[r_rd] &
      (iResTarget != r_tgt[r_rd])));

  // A mispredict squashes any same-cycle push as wrong-path.
  assign w_push = w_idle & iPredValid &
    (~r_full | w_pop) & ~w_mis;

  assign w_redir_pc = iResTaken ? iResTarget
                    : r_pc[r_rd] + ADDR_W'(4);

  assign w_cnt_nxt = w_mis ? '0
    : r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_mis) begin
          w_state_nxt = S_FLUSH;
          w_fcnt_nxt  = FCW'(FLUSH_CYCLES);
        end
      end
      S_FLUSH: begin
        w_fcnt_nxt = r_fcnt - FCW'(1);
        if (r_fcnt == FCW'(1))
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= S_IDLE;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_ff @(posedge iClk) begin
    if (w_push) begin
      r_taken[r_wr] <= iPredTaken;
      r_pc[r_wr]    <= iPredPC;
      r_tgt[r_wr]   <= iPredTarget;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_mis) begin
        r_wr <= '0;
        r_rd <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + AW'(1);
        if (w_pop)  r_rd <= r_rd + AW'(1);
      end
      r_count <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_upd_cmd   <= 1'b0;
      r_upd_taken <= 1'b0;
      r_mis       <= 1'b0;
      r_redir_v   <= 1'b0;
      r_redir_pc  <= '0;
    end else begin
      r_upd_cmd   <= w_pop;
      r_upd_taken <= w_pop & iResTaken;
      r_mis       <= w_mis;
      r_redir_v   <= w_mis;
      if (w_mis) r_redir_pc <= w_redir_pc;
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0] r_br_cnt;
  logic [15:0] r_mis_cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      if (w_pop && r_br_cnt != 16'hFFFF)
        r_br_cnt <= r_br_cnt + 16'd1;
      if (w_mis && r_mis_cnt != 16'hFFFF)
        r_mis_cnt <= r_mis_cnt + 16'd1;
    end
  end

  assign oBranchCount  = r_br_cnt;
  assign oMispredCount = r_mis_cnt;
`endif

  assign oPredFull      = r_full;
  assign oEmpty         = r_empty;
  assign oUpdCmd        = r_upd_cmd;
  assign oUpdTaken      = r_upd_taken;
  assign oMispredict    = r_mis;
  assign oRedirectValid = r_redir_v;
  assign oRedirectPC    = r_redir_pc;
  assign oFlush         = (r_state == S_FLUSH);

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: reference FIFO model, expected
// training/redirect results queued at resolve, compared when oUpdCmd fires.
module tb_branch_resolver;

  localparam int AW = 32;
  localparam int DP = 4;
  localparam int FC = 2;

  logic          iClk = 1'b0;
  logic          iRst_n;
  logic          iPredValid, iPredTaken;
  logic [AW-1:0] iPredPC, iPredTarget;
  logic          oPredFull, oEmpty;
  logic          iResValid, iResTaken;
  logic [AW-1:0] iResTarget;
  logic          oUpdCmd, oUpdTaken, oMispredict;
  logic          oRedirectValid, oFlush;
  logic [AW-1:0] oRedirectPC;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0]   oBranchCount, oMispredCount;
`endif

  branch_resolver #(
    .ADDR_W(AW), .DEPTH(DP), .FLUSH_CYCLES(FC)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iPredValid(iPredValid), .iPredTaken(iPredTaken),
    .iPredPC(iPredPC), .iPredTarget(iPredTarget),
    .oPredFull(oPredFull), .oEmpty(oEmpty),
    .iResValid(iResValid), .iResTaken(iResTaken),
    .iResTarget(iResTarget),
    .oUpdCmd(oUpdCmd), .oUpdTaken(oUpdTaken),
    .oMispredict(oMispredict),
    .oRedirectValid(oRedirectValid),
    .oRedirectPC(oRedirectPC), .oFlush(oFlush)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .oBranchCount(oBranchCount),
    .oMispredCount(oMispredCount)
`endif
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic          t;
    logic [AW-1:0] pc;
    logic [AW-1:0] tg;
  } ent_t;

  typedef struct {
    logic          tk;
    logic          mis;
    logic [AW-1:0] rpc;
  } exp_t;

  ent_t          mq[$];
  exp_t          sb[$];
  int            m_flush;
  logic          m_upd;
  logic [AW-1:0] m_rpc;
  int            n_run, n_fail, n_upd;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    m_flush = 0;
    m_upd   = 1'b0;
    m_rpc   = '0;
  endtask

  task automatic check_idle_outs(string tag);
    check({tag, "_flush"}, 32'(oFlush), 0);
    check({tag, "_redv"}, 32'(oRedirectValid), 0);
    check({tag, "_upd"}, 32'(oUpdCmd), 0);
    check({tag, "_mis"}, 32'(oMispredict), 0);
    check({tag, "_empty"}, 32'(oEmpty), 1);
    check({tag, "_full"}, 32'(oPredFull), 0);
    check({tag, "_rpc"}, oRedirectPC, 0);
`ifdef BRANCH_RESOLVER_STATS_EN
    check({tag, "_brcnt"}, 32'(oBranchCount), 0);
    check({tag, "_miscnt"}, 32'(oMispredCount), 0);
`endif
  endtask

  task automatic step(input logic pv, input logic pt,
                      input logic [AW-1:0] ppc,
                      input logic [AW-1:0] ptg,
                      input logic rv, input logic rt,
                      input logic [AW-1:0] rtg);
    ent_t h;
    exp_t e;
    logic pop, push, mis;
    @(negedge iClk);
    iPredValid = pv; iPredTaken = pt;
    iPredPC = ppc;   iPredTarget = ptg;
    iResValid = rv;  iResTaken = rt;
    iResTarget = rtg;
    m_upd = 1'b0;
    if (m_flush > 0) begin
      m_flush--;
    end else begin
      pop  = rv && (mq.size() > 0);
      push = pv && (mq.size() < DP || pop);
      mis  = 1'b0;
      if (pop) begin
        h = mq.pop_front();
        mis = (rt != h.t) || (rt && h.t && rtg != h.tg);
        e.tk  = rt;
        e.mis = mis;
        e.rpc = rt ? rtg : h.pc + 32'd4;
        sb.push_back(e);
        m_upd = 1'b1;
        if (mis) begin
          mq.delete();
          m_flush = FC;
          m_rpc = e.rpc;
        end
      end
      if (push && !mis) begin
        h.t = pt; h.pc = ppc; h.tg = ptg;
        mq.push_back(h);
      end
    end
    @(posedge iClk);
    #1;
    check("upd", 32'(oUpdCmd), 32'(m_upd));
    if (oUpdCmd) begin
      if (sb.size() == 0) begin
        check("sb_empty", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        n_upd++;
        check("upd_taken", 32'(oUpdTaken), 32'(e.tk));
        check("mispredict", 32'(oMispredict), 32'(e.mis));
        check("redir_v", 32'(oRedirectValid), 32'(e.mis));
      end
    end else begin
      check("mis_quiet", 32'(oMispredict), 0);
      check("redv_quiet", 32'(oRedirectValid), 0);
    end
    check("redir_pc", oRedirectPC, m_rpc);
    check("flush", 32'(oFlush), 32'(m_flush > 0));
    check("empty", 32'(oEmpty), 32'(mq.size() == 0));
    check("full", 32'(oPredFull), 32'(mq.size() == DP));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic push(logic t, logic [AW-1:0] pc,
                      logic [AW-1:0] tg);
    step(1, t, pc, tg, 0, 0, '0);
  endtask

  task automatic resolve(logic t, logic [AW-1:0] tg);
    step(0, 0, '0, '0, 1, t, tg);
  endtask

  int base;

  initial begin
    n_run = 0; n_fail = 0; n_upd = 0;
    model_clear();
    iRst_n = 1'b1;
    iPredValid = 0; iPredTaken = 0;
    iPredPC = '0; iPredTarget = '0;
    iResValid = 0; iResTaken = 0; iResTarget = '0;
    #2 iRst_n = 1'b0;
    #2;
    check_idle_outs("reset");
    @(negedge iClk);
    iRst_n = 1'b1;

    // correct not-taken
    push(0, 32'h100, 32'h0);
    resolve(0, 32'h0);
    check("nt_updtaken", 32'(oUpdTaken), 0);
    idle(1);

    // direction mispredict
    push(0, 32'h200, 32'h0);
    resolve(1, 32'h340);
    check("dir_rpc", oRedirectPC, 32'h340);
    idle(3);

    // target mispredict, then wrapping fall-through
    push(1, 32'h300, 32'h400);
    resolve(1, 32'h480);
    check("tgt_rpc", oRedirectPC, 32'h480);
    idle(3);
    push(1, 32'hFFFF_FFFC, 32'h10);
    resolve(0, 32'h0);
    check("wrap_rpc", oRedirectPC, 32'h0);
    check("wrap_redv", 32'(oRedirectValid), 1);
    idle(3);

    // full / overflow
    for (int i = 0; i < 5; i++)
      push(0, 32'h1000 + 32'(i * 4), 32'h0);
    check("ovf_full", 32'(oPredFull), 1);
    step(1, 0, 32'h2000, 32'h0, 1, 0, 32'h0);
    check("pp_full", 32'(oPredFull), 1);
    base = n_upd;
    for (int i = 0; i < 4; i++)
      resolve(0, 32'h0);
    check("drain_pulses", 32'(n_upd - base), 4);
    check("drain_empty", 32'(oEmpty), 1);
    idle(1);

    // flush masking with same-cycle push
    for (int i = 0; i < 3; i++)
      push(1, 32'h500 + 32'(i * 4), 32'h800);
    step(1, 0, 32'h600, 32'h0, 1, 0, 32'h0);
    check("mask_rpc", oRedirectPC, 32'h504);
    base = n_upd;
    step(1, 1, 32'h700, 32'h800, 1, 1, 32'h800);
    step(1, 1, 32'h704, 32'h800, 1, 1, 32'h800);
    check("mask_noupd", 32'(n_upd - base), 0);
    idle(1);
    check("mask_empty", 32'(oEmpty), 1);

    // async reset mid-flush
    push(0, 32'h900, 32'h0);
    resolve(1, 32'hA00);
    check("pre_rst_flush", 32'(oFlush), 1);
    #2 iRst_n = 1'b0;
    #1;
    model_clear();
    check_idle_outs("midrst");
    @(negedge iClk);
    iRst_n = 1'b1;
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           32'h4000 + 32'($urandom_range(0, 15) * 4),
           $urandom_range(0, 1) ? 32'h800 : 32'h900,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 1) ? 32'h800 : 32'h900);
    idle(4);
    check("sb_drain", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
